// File: rtl/prach_nco_pkg.sv
// Shared constants and types for the PRACH NCO sequencer.
package prach_nco_pkg;

  localparam int NumChn   = 8;
  localparam int FcwWidth = 16;
  localparam int ChnWidth = $clog2(NumChn);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_e;

  typedef logic [NumChn-1:0][FcwWidth-1:0] fcw_arr_t;

endpackage

// File: rtl/prach_rr_pick.sv
// Round-robin pick: first set mask bit strictly after ptr, wrapping,
// with ptr itself considered last. NUM_CHN must be a power of two.
module prach_rr_pick #(
  parameter int NUM_CHN = 8
) (
  input  logic [NUM_CHN-1:0]         mask,
  input  logic [$clog2(NUM_CHN)-1:0] ptr,
  output logic                       found,
  output logic [$clog2(NUM_CHN)-1:0] index
);

  localparam int CW = $clog2(NUM_CHN);

  // Scan offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = NUM_CHN; k >= 1; k--) begin
      if (mask[ptr + CW'(k)]) begin
        found = 1'b1;
        index = ptr + CW'(k);
      end
    end
  end

endmodule

// File: rtl/prach_nco_ctrl.sv
// PRACH NCO sequencer / FCW front-end.
// Optional slot counter: define PRACH_NCO_CTRL_SLOT_CNT_EN to build it;
// otherwise stat_slot_cnt is tied to zero.
// Outputs are registered from the next-cycle decision, so nco_sync appears
// the cycle after frame_start and the first nco_dv the cycle after nco_sync.
module prach_nco_ctrl
  import prach_nco_pkg::*;
#(
  parameter int NUM_CHN = NumChn,
  parameter int FCW_W   = FcwWidth,
  parameter int DIV_W   = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            frame_start,
  input  logic [DIV_W-1:0]                ctrl_div,
  input  logic [NUM_CHN-1:0]              ctrl_chn_mask,
  input  logic                            cfg_wr,
  input  logic [$clog2(NUM_CHN)-1:0]      cfg_chn,
  input  logic [FCW_W-1:0]                cfg_fcw,
  input  logic                            cfg_commit,
  output logic                            nco_dv,
  output logic [7:0]                      nco_chn,
  output logic                            nco_sync,
  output logic [NUM_CHN-1:0][FCW_W-1:0]   nco_fcw,
  output logic                            commit_pending,
  output logic [15:0]                     stat_slot_cnt
);

  localparam int CW = $clog2(NUM_CHN);

  state_e                         state, state_nxt;
  logic [DIV_W-1:0]               div_cnt, div_nxt;
  logic [CW-1:0]                  ptr, pick_idx;
  logic                           pick_found, slot_nxt;
  logic [NUM_CHN-1:0][FCW_W-1:0]  shadow;

  prach_rr_pick #(.NUM_CHN(NUM_CHN)) u_pick (
    .mask  (ctrl_chn_mask),
    .ptr   (ptr),
    .found (pick_found),
    .index (pick_idx)
  );

  // Next state, divider phase and slot decision for the coming cycle.
  always_comb begin
    state_nxt = state;
    div_nxt   = '0;
    case (state)
      IDLE:    if (enable && frame_start) state_nxt = SYNC;
      SYNC:    state_nxt = enable ? RUN : IDLE;
      RUN: begin
        if (!enable)          state_nxt = IDLE;
        else if (frame_start) state_nxt = SYNC;
      end
      default: state_nxt = IDLE;
    endcase
    // Phase restarts at 0 on the first RUN cycle after SYNC.
    if (state == RUN && state_nxt == RUN && div_cnt < ctrl_div)
      div_nxt = div_cnt + DIV_W'(1);
    slot_nxt = (state_nxt == RUN) && (div_nxt == '0) && pick_found;
  end

  // Sequencer state and NCO strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      ptr      <= '1;
      nco_dv   <= 1'b0;
      nco_chn  <= '0;
      nco_sync <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_cnt  <= div_nxt;
      nco_sync <= (state_nxt == SYNC);
      nco_dv   <= slot_nxt;
      if (state_nxt == SYNC) begin
        ptr <= '1;
      end else if (slot_nxt) begin
        ptr     <= pick_idx;
        nco_chn <= 8'(pick_idx);
      end
    end
  end

  // Shadow/active FCWs; the copy at the end of SYNC sees the pre-write shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow         <= '0;
      nco_fcw        <= '0;
      commit_pending <= 1'b0;
    end else begin
      if (cfg_wr) shadow[cfg_chn] <= cfg_fcw;
      if (state == SYNC && commit_pending) nco_fcw <= shadow;
      // A commit landing in the SYNC cycle stays pending for the next frame.
      commit_pending <= cfg_commit | (commit_pending & (state != SYNC));
    end
  end

`ifdef PRACH_NCO_CTRL_SLOT_CNT_EN
  // Saturating count of slots issued since the last sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stat_slot_cnt <= '0;
    else if (state_nxt == SYNC)
      stat_slot_cnt <= '0;
    else if (slot_nxt && stat_slot_cnt != 16'hFFFF)
      stat_slot_cnt <= stat_slot_cnt + 16'd1;
  end
`else
  assign stat_slot_cnt = '0;
`endif

endmodule

// File: tb/tb_prach_nco_ctrl.sv
// Self-checking bench for prach_nco_ctrl: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_prach_nco_ctrl;
  import prach_nco_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        frame_start = 1'b0;
  logic [7:0]  ctrl_div = '0;
  logic [7:0]  ctrl_chn_mask = '0;
  logic        cfg_wr = 1'b0;
  logic [2:0]  cfg_chn = '0;
  logic [15:0] cfg_fcw = '0;
  logic        cfg_commit = 1'b0;
  logic        nco_dv, nco_sync, commit_pending;
  logic [7:0]  nco_chn;
  logic [7:0][15:0] nco_fcw;
  logic [15:0] stat_slot_cnt;

  int checks = 0;
  int errors = 0;

  prach_nco_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .frame_start(frame_start),
    .ctrl_div(ctrl_div), .ctrl_chn_mask(ctrl_chn_mask),
    .cfg_wr(cfg_wr), .cfg_chn(cfg_chn), .cfg_fcw(cfg_fcw), .cfg_commit(cfg_commit),
    .nco_dv(nco_dv), .nco_chn(nco_chn), .nco_sync(nco_sync), .nco_fcw(nco_fcw),
    .commit_pending(commit_pending), .stat_slot_cnt(stat_slot_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: what the NCO should see during the current cycle.
  bit       m_sync, m_run, m_dv, m_pend;
  int       m_phase, m_last, m_chn, m_cnt;
  fcw_arr_t m_shadow, m_active;

  function automatic int next_active(input logic [7:0] mask, input int last);
    for (int k = 1; k <= 8; k++) if (mask[(last + k) % 8]) return (last + k) % 8;
    return -1;
  endfunction

  function void model_reset();
    m_sync = 0; m_run = 0; m_dv = 0; m_pend = 0;
    m_phase = 0; m_last = 7; m_chn = 0; m_cnt = 0;
    m_shadow = '0; m_active = '0;
  endfunction

  function int exp_cnt();
`ifdef PRACH_NCO_CTRL_SLOT_CNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  // Apply the frame/slot rules to the inputs present before the coming edge.
  function void model_step();
    bit was_sync, go_sync, go_run;
    int c;
    was_sync = m_sync;
    if (was_sync && m_pend) m_active = m_shadow;
    if (cfg_wr) m_shadow[cfg_chn] = cfg_fcw;
    m_pend = cfg_commit || (m_pend && !was_sync);
    go_sync = 0; go_run = 0;
    if (was_sync)   go_run = enable;
    else if (m_run) begin
      if (enable) begin
        if (frame_start) go_sync = 1; else go_run = 1;
      end
    end else if (enable && frame_start) go_sync = 1;
    if (go_sync) begin m_last = 7; m_cnt = 0; end
    m_dv = 0;
    if (go_run) begin
      if (was_sync) m_phase = 0;
      else m_phase = (m_phase >= int'(ctrl_div)) ? 0 : m_phase + 1;
      c = next_active(ctrl_chn_mask, m_last);
      if (m_phase == 0 && c >= 0) begin
        m_dv = 1; m_last = c; m_chn = c;
        if (m_cnt < 65535) m_cnt++;
      end
    end else m_phase = 0;
    m_sync = go_sync;
    m_run  = go_run;
  endfunction

  task tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task test_reset();
    model_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (nco_dv !== 1'b0 || nco_sync !== 1'b0 || nco_chn !== 8'd0 || commit_pending !== 1'b0 ||
        stat_slot_cnt !== 16'd0 || nco_fcw !== '0) begin
      errors++;
      $display("FAIL reset: dv=%b sync=%b chn=%0d pend=%b cnt=%0d fcw=%h, all required 0",
               nco_dv, nco_sync, nco_chn, commit_pending, stat_slot_cnt, nco_fcw);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task test_full_mask();
    enable = 1; ctrl_chn_mask = 8'hFF; ctrl_div = 0; frame_start = 1;
    tick();
    frame_start = 0;
    checks++;
    if (nco_sync !== 1'b1 || nco_dv !== 1'b0) begin
      errors++; $display("FAIL full_sync: sync=%b dv=%b required 1/0", nco_sync, nco_dv);
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (nco_dv !== 1'b1 || nco_chn !== 8'(i % 8) || nco_sync !== 1'b0) begin
        errors++;
        $display("FAIL full_seq[%0d]: dv=%b chn=%0d sync=%b required 1/%0d/0", i, nco_dv, nco_chn, nco_sync, i % 8);
      end
    end
  endtask

  task test_sparse_mask();
    int seq [4] = '{2, 5, 7, 2};
    ctrl_chn_mask = 8'b1010_0100; ctrl_div = 2; frame_start = 1;
    tick();
    frame_start = 0;
    checks++;
    if (nco_sync !== 1'b1) begin errors++; $display("FAIL sparse_sync: sync=%b required 1", nco_sync); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (nco_dv !== (i % 3 == 0) || (i % 3 == 0 && nco_chn !== 8'(seq[i / 3]))) begin
        errors++;
        $display("FAIL sparse_seq[%0d]: dv=%b chn=%0d required dv=%b chn=%0d", i, nco_dv, nco_chn, (i % 3 == 0), seq[i / 3]);
      end
    end
    ctrl_chn_mask = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (nco_dv !== 1'b0) begin errors++; $display("FAIL empty_mask[%0d]: dv=%b required 0", i, nco_dv); end
    end
  endtask

  task test_commit();
    ctrl_chn_mask = 8'hFF; ctrl_div = 0;
    cfg_wr = 1; cfg_chn = 3; cfg_fcw = 16'h1234;
    tick();
    cfg_wr = 0; cfg_commit = 1;
    tick();
    cfg_commit = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      // Active words are still the reset value until the next frame.
      if (nco_fcw[3] !== 16'h0000 || commit_pending !== 1'b1) begin
        errors++; $display("FAIL commit_hold[%0d]: fcw3=%h pend=%b required 0000/1", i, nco_fcw[3], commit_pending);
      end
      tick();
    end
    frame_start = 1;
    tick();
    frame_start = 0;
    checks++;
    if (nco_sync !== 1'b1 || nco_fcw[3] !== 16'h0000 || commit_pending !== 1'b1) begin
      errors++; $display("FAIL commit_sync: sync=%b fcw3=%h pend=%b required 1/0000/1", nco_sync, nco_fcw[3], commit_pending);
    end
    tick();
    checks++;
    if (nco_fcw[3] !== 16'h1234 || commit_pending !== 1'b0 || nco_dv !== 1'b1 || nco_chn !== 8'd0) begin
      errors++;
      $display("FAIL commit_apply: fcw3=%h pend=%b dv=%b chn=%0d required 1234/0/1/0", nco_fcw[3], commit_pending, nco_dv, nco_chn);
    end
  endtask

  task test_fs_on_slot();
    ctrl_chn_mask = 8'b0101_0100; ctrl_div = 0;
    repeat (3) tick();
    checks++;
    if (nco_dv !== 1'b1) begin errors++; $display("FAIL fs_pre: dv=%b required 1", nco_dv); end
    frame_start = 1;
    tick();
    frame_start = 0;
    checks++;
    if (nco_sync !== 1'b1 || nco_dv !== 1'b0) begin
      errors++; $display("FAIL fs_suppress: sync=%b dv=%b required 1/0", nco_sync, nco_dv);
    end
    tick();
    checks++;
    if (nco_dv !== 1'b1 || nco_chn !== 8'd2) begin
      errors++; $display("FAIL fs_restart: dv=%b chn=%0d required 1/2", nco_dv, nco_chn);
    end
    tick();
    checks++;
    if (nco_dv !== 1'b1 || nco_chn !== 8'd4) begin
      errors++; $display("FAIL fs_next: dv=%b chn=%0d required 1/4", nco_dv, nco_chn);
    end
  endtask

  task test_enable_drop();
    ctrl_chn_mask = 8'hFF; ctrl_div = 0;
    enable = 0;
    tick();
    checks++;
    if (nco_dv !== 1'b0 || nco_sync !== 1'b0) begin
      errors++; $display("FAIL en_drop: dv=%b sync=%b required 0/0", nco_dv, nco_sync);
    end
    frame_start = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (nco_sync !== 1'b0 || nco_dv !== 1'b0) begin
        errors++; $display("FAIL idle_fs[%0d]: sync=%b dv=%b required 0/0", i, nco_sync, nco_dv);
      end
    end
    frame_start = 0; enable = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (nco_sync !== 1'b0 || nco_dv !== 1'b0) begin
        errors++; $display("FAIL idle_en[%0d]: sync=%b dv=%b required 0/0", i, nco_sync, nco_dv);
      end
    end
    frame_start = 1;
    tick();
    frame_start = 0;
    tick();
    checks++;
    if (nco_dv !== 1'b1 || nco_chn !== 8'd0) begin
      errors++; $display("FAIL en_resume: dv=%b chn=%0d required 1/0", nco_dv, nco_chn);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (nco_dv !== 1'b0 || nco_sync !== 1'b0 || nco_fcw !== '0 || commit_pending !== 1'b0) begin
      errors++; $display("FAIL async_rst: dv=%b sync=%b pend=%b fcw=%h required all 0", nco_dv, nco_sync, commit_pending, nco_fcw);
    end
    model_reset();
    rst_n = 1'b1;
  endtask

  task test_slot_cnt();
    int exp10;
`ifdef PRACH_NCO_CTRL_SLOT_CNT_EN
    exp10 = 10;
`else
    exp10 = 0;
`endif
    enable = 1; ctrl_chn_mask = 8'hFF; ctrl_div = 0; frame_start = 1;
    tick();
    frame_start = 0;
    checks++;
    if (stat_slot_cnt !== 16'd0 || nco_sync !== 1'b1) begin
      errors++; $display("FAIL cnt_start: cnt=%0d sync=%b required 0/1", stat_slot_cnt, nco_sync);
    end
    repeat (10) tick();
    checks++;
    if (stat_slot_cnt !== 16'(exp10)) begin
      errors++; $display("FAIL cnt_ten: cnt=%0d required %0d", stat_slot_cnt, exp10);
    end
    frame_start = 1;
    tick();
    frame_start = 0;
    checks++;
    if (stat_slot_cnt !== 16'd0 || nco_sync !== 1'b1) begin
      errors++; $display("FAIL cnt_clear: cnt=%0d sync=%b required 0/1", stat_slot_cnt, nco_sync);
    end
  endtask

  task test_random();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      enable      = ($urandom_range(0, 99) != 0);
      frame_start = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 19) == 0) begin
        ctrl_chn_mask = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
        ctrl_div      = 8'($urandom_range(0, 3));
      end
      cfg_wr     = ($urandom_range(0, 4) == 0);
      cfg_chn    = 3'($urandom);
      cfg_fcw    = 16'($urandom);
      cfg_commit = ($urandom_range(0, 19) == 0);
      tick();
      checks++;
      if (nco_dv !== m_dv || nco_sync !== m_sync || (m_dv && nco_chn !== 8'(m_chn)) ||
          nco_fcw !== m_active || commit_pending !== m_pend || stat_slot_cnt !== 16'(exp_cnt())) begin
        errors++;
        $display("FAIL random[%0d]: dv=%b/%b sync=%b/%b chn=%0d/%0d pend=%b/%b cnt=%0d/%0d fcw=%h/%h",
                 cyc, nco_dv, m_dv, nco_sync, m_sync, nco_chn, m_chn, commit_pending, m_pend,
                 stat_slot_cnt, exp_cnt(), nco_fcw, m_active);
      end
    end
    cfg_wr = 0; cfg_commit = 0; frame_start = 0;
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_sparse_mask();
    test_commit();
    test_fs_on_slot();
    test_enable_drop();
    test_slot_cnt();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
